gcd_core: RTL and testbench

Iterative greatest-common-divisor engine using repeated subtraction (Euclid). Takes two unsigned operands on a load strobe, computes over multiple cycles, and presents the result with a one-cycle ready pulse. It is a standalone datapath/FSM block driven by a host that issues one load at a time and waits for ready.

---
 rtl/gcd_core.sv | 121 ++++++++++++
 tb/tb_gcd_core.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/gcd_core.sv
// -----------------------------------------------------------------------------
// gcd_core
//
// Iterative greatest-common-divisor engine based on Euclid's repeated
// subtraction. A host pulses ld with two unsigned operands. The engine then
// subtracts the smaller register from the larger once per clock until one
// register is zero or both are equal. It then presents the result on q
// together with a single-cycle rdy pulse.
//
// Parameters
//   WIDTH    operand / result width in bits (unsigned), default 8
//
// Ports
//   clk      in   1      rising-edge clock, the only clock
//   reset    in   1      synchronous active-low reset (0 = reset)
//   a        in   WIDTH  operand A, captured on the edge where ld=1
//   b        in   WIDTH  operand B, captured on the edge where ld=1
//   ld       in   1      load strobe, starts (or restarts) a computation
//   q        out  WIDTH  result, held until the next completion
//   rdy      out  1      one-cycle pulse per completed computation
//   busy     out  1      (only with GCD_BUSY_EN) high while computing
//
// Build option
//   GCD_BUSY_EN  when defined, adds the busy output (state == RUN).
// -----------------------------------------------------------------------------
module gcd_core #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ld,
   output logic [WIDTH-1:0] q,
`ifdef GCD_BUSY_EN
   output logic             busy,
`endif
   output logic             rdy
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]       r_state;
   logic [WIDTH-1:0] r_ra;
   logic [WIDTH-1:0] r_rb;
   logic [WIDTH-1:0] r_q;
   logic             r_rdy;

   logic             w_ra_zero;
   logic             w_rb_zero;
   logic             w_equal;
   logic             w_ra_gt;
   logic [WIDTH-1:0] w_ra_minus_rb;
   logic [WIDTH-1:0] w_rb_minus_ra;

   // Termination tests and both candidate differences. Only the difference
   // whose minuend is the larger register is ever committed, so the
   // subtraction cannot wrap.
   assign w_ra_zero     = (r_ra == '0);
   assign w_rb_zero     = (r_rb == '0);
   assign w_equal       = (r_ra == r_rb);
   assign w_ra_gt       = (r_ra > r_rb);
   assign w_ra_minus_rb = r_ra - r_rb;
   assign w_rb_minus_ra = r_rb - r_ra;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_ra    <= '0;
         r_rb    <= '0;
         r_q     <= '0;
         r_rdy   <= 1'b0;
      end else begin
         // rdy is a pulse. It drops on every edge unless a completion
         // happens on that same edge.
         r_rdy <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (ld) begin
                  r_ra    <= a;
                  r_rb    <= b;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (ld) begin
                  // A new load abandons the in-flight computation silently.
                  r_ra <= a;
                  r_rb <= b;
               end else if (w_ra_zero) begin
                  r_q     <= r_rb;
                  r_rdy   <= 1'b1;
                  r_state <= S_IDLE;
               end else if (w_rb_zero || w_equal) begin
                  r_q     <= r_ra;
                  r_rdy   <= 1'b1;
                  r_state <= S_IDLE;
               end else if (w_ra_gt) begin
                  r_ra <= w_ra_minus_rb;
               end else begin
                  r_rb <= w_rb_minus_ra;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign q   = r_q;
   assign rdy = r_rdy;

`ifdef GCD_BUSY_EN
   // busy follows the state directly. It is therefore low on the same cycle
   // that rdy rises.
   assign busy = (r_state == S_RUN);
`endif

endmodule

// File: tb/tb_gcd_core.sv
module tb_gcd_core;

   localparam int WIDTH = 8;

   logic             clk;
   logic             reset;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ld;
   logic [WIDTH-1:0] q;
   logic             rdy;
`ifdef GCD_BUSY_EN
   logic             busy;
`endif

   int n_cmp;
   int n_err;

   gcd_core #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .a     (a),
      .b     (b),
      .ld    (ld),
      .q     (q),
`ifdef GCD_BUSY_EN
      .busy  (busy),
`endif
      .rdy   (rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: Euclid by remainders.
   function automatic int unsigned ref_gcd(int unsigned x, int unsigned y);
      int unsigned t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // Edges from the load edge to the rdy pulse. This equals one plus the
   // number of subtractions. That count is the sum of the Euclidean
   // quotients minus one, because the final quotient ends on equality.
   function automatic int unsigned ref_lat(int unsigned x, int unsigned y);
      int unsigned s;
      int unsigned t;
      if (x == 0 || y == 0) return 1;
      s = 0;
      while (y != 0) begin
         s = s + x / y;
         t = x % y;
         x = y;
         y = t;
      end
      return s;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one rising edge. Inputs are driven and outputs are sampled
   // 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input int unsigned x, input int unsigned y, input string tag);
      a  = x[WIDTH-1:0];
      b  = y[WIDTH-1:0];
      ld = 1'b1;
      step();
      ld = 1'b0;
      chk({tag, "_rdy_after_ld"}, rdy, 1'b0);
`ifdef GCD_BUSY_EN
      chk({tag, "_busy_after_ld"}, busy, 1'b1);
`endif
   endtask

   // Returns with the bench sitting in the cycle where rdy is high.
   task automatic wait_result(input int unsigned x, input int unsigned y, input string tag);
      int n;
      n = 1;
      step();
      while (rdy !== 1'b1 && n < 300) begin
         n++;
         step();
      end
      chk({tag, "_lat"}, n, ref_lat(x, y));
      chk({tag, "_q"}, q, ref_gcd(x, y));
`ifdef GCD_BUSY_EN
      chk({tag, "_busy_at_rdy"}, busy, 1'b0);
`endif
   endtask

   task automatic check_pulse_end(input int unsigned exp_q, input string tag);
      step();
      chk({tag, "_rdy_drop"}, rdy, 1'b0);
      chk({tag, "_q_hold"}, q, exp_q);
   endtask

   int pulses;
   int unsigned x;
   int unsigned y;
   int unsigned px;
   int unsigned py;

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b0;
      ld    = 1'b0;
      a     = '0;
      b     = '0;

      // Reset held with activity on the inputs.
      for (int i = 0; i < 3; i++) begin
         ld = i[0];
         a  = 8'(i * 37 + 5);
         b  = 8'(i * 11 + 3);
         step();
         chk("rst_q", q, 0);
         chk("rst_rdy", rdy, 1'b0);
`ifdef GCD_BUSY_EN
         chk("rst_busy", busy, 1'b0);
`endif
      end
      ld    = 1'b0;
      reset = 1'b1;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (rdy === 1'b1) pulses++;
      end
      chk("idle_no_rdy", pulses, 0);

      // Directed cases.
      do_load(12, 8, "g12_8");
      wait_result(12, 8, "g12_8");
      check_pulse_end(4, "g12_8");
      step();
      chk("g12_8_q_hold2", q, 4);

      do_load(0, 0, "g0_0");   wait_result(0, 0, "g0_0");   check_pulse_end(0, "g0_0");
      do_load(7, 0, "g7_0");   wait_result(7, 0, "g7_0");   check_pulse_end(7, "g7_0");
      do_load(0, 9, "g0_9");   wait_result(0, 9, "g0_9");   check_pulse_end(9, "g0_9");
      do_load(5, 5, "g5_5");   wait_result(5, 5, "g5_5");   check_pulse_end(5, "g5_5");
      do_load(255, 1, "g255_1"); wait_result(255, 1, "g255_1"); check_pulse_end(1, "g255_1");
      do_load(128, 96, "g128_96"); wait_result(128, 96, "g128_96"); check_pulse_end(32, "g128_96");

      // Abort: the second load replaces the first pair, giving one rdy only.
      do_load(200, 3, "abort1");
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (rdy === 1'b1) pulses++;
      end
      chk("abort_early_rdy", pulses, 0);
      do_load(18, 12, "abort2");
      wait_result(18, 12, "abort2");
      pulses = 0;
      for (int i = 0; i < 300; i++) begin
         step();
         if (rdy === 1'b1) pulses++;
      end
      chk("abort_extra_rdy", pulses, 0);
      chk("abort_q_hold", q, 6);

      // Reset in the middle of a long computation.
      do_load(255, 1, "midrst");
      for (int i = 0; i < 10; i++) step();
      reset = 1'b0;
      step();
      chk("midrst_q", q, 0);
      chk("midrst_rdy", rdy, 1'b0);
`ifdef GCD_BUSY_EN
      chk("midrst_busy", busy, 1'b0);
`endif
      reset = 1'b1;
      pulses = 0;
      for (int i = 0; i < 300; i++) begin
         step();
         if (rdy === 1'b1) pulses++;
      end
      chk("midrst_no_rdy", pulses, 0);

      // Random pairs. Each next load is issued in the cycle where rdy is high.
      px = $urandom_range(0, 255);
      py = $urandom_range(0, 255);
      do_load(px, py, "rnd_first");
      for (int k = 0; k < 100; k++) begin
         wait_result(px, py, $sformatf("rnd%0d", k));
         if (k < 99) begin
            x = $urandom_range(0, 255);
            y = $urandom_range(0, 255);
            if (k % 10 == 3) y = x;
            if (k % 17 == 5) x = 0;
            do_load(x, y, $sformatf("rnd%0d_ld", k + 1));
            px = x;
            py = y;
         end
      end
      check_pulse_end(ref_gcd(px, py), "rnd_last");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
